gate_sequencer: RTL and testbench

//  Sequences the gate/reset inputs of NUM_CH input_counter instances: clears them, opens a gate

---
 rtl/gate_sequencer_pkg.sv | 15 +
 rtl/gate_sequencer_timer.sv | 30 +++
 rtl/gate_sequencer.sv | 101 ++++++++++
 tb/tb_gate_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sequencer_pkg.sv
// Shared types and defaults for the gate sequencer and the counter wrapper that uses it.
package gate_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COUNT = 2'd2,
        LATCH = 2'd3
    } gseq_state_t;

    localparam int CNT_W_DEF = 32;
    localparam int DUR_W_DEF = 32;
    localparam int WIN_W     = 16;

endpackage

// File: rtl/gate_sequencer_timer.sv
// Loadable down-counter that times the gate window; expires on its last enabled cycle.
module gate_timer #(
    parameter int DUR_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [DUR_W-1:0] i_value,
    output logic             o_expire
);

    localparam logic [DUR_W-1:0] ONE = {{(DUR_W-1){1'b0}}, 1'b1};

    logic [DUR_W-1:0] value;

    // Counting down and stopping at zero avoids any overflow, even for the maximum duration.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            value <= '0;
        end else if (i_load) begin
            value <= i_value;
        end else if (i_enable && value != '0) begin
            value <= value - ONE;
        end
    end

    assign o_expire = i_enable && (value == ONE);

endmodule

// File: rtl/gate_sequencer.sv
// Drives counter clear/gate, times the window and snapshots all channel counts for readout.
module gate_sequencer
    import gate_sequencer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DUR_W  = DUR_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_repeat,
    input  logic [DUR_W-1:0]        i_duration,
    input  logic [NUM_CH*CNT_W-1:0] i_counts,
    output logic                    o_cnt_reset,
    output logic                    o_gate,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic [NUM_CH*CNT_W-1:0] o_counts,
    output logic [WIN_W-1:0]        o_windows
);

    localparam logic [DUR_W-1:0] ONE = {{(DUR_W-1){1'b0}}, 1'b1};

    gseq_state_t      state;
    logic [DUR_W-1:0] load_value;
    logic             expire;

    // A zero duration would never expire, so it is promoted to a single-cycle window.
    assign load_value = (i_duration == '0) ? ONE : i_duration;

    gate_timer #(
        .DUR_W (DUR_W)
    ) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (state == CLEAR),
        .i_enable (state == COUNT),
        .i_value  (load_value),
        .o_expire (expire)
    );

    // Outputs are registered on the transition into each state, so they line up with it.
    // Counts are captured as the gate closes, making them visible together with o_valid.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            o_cnt_reset <= 1'b0;
            o_gate      <= 1'b0;
            o_busy      <= 1'b0;
            o_valid     <= 1'b0;
            o_counts    <= '0;
            o_windows   <= '0;
        end else begin
            o_valid     <= 1'b0;
            o_cnt_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !i_stop) begin
                        state       <= CLEAR;
                        o_cnt_reset <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    state  <= COUNT;
                    o_gate <= 1'b1;
                end
                COUNT: begin
                    if (i_stop) begin
                        state  <= IDLE;
                        o_gate <= 1'b0;
                        o_busy <= 1'b0;
                    end else if (expire) begin
                        state     <= LATCH;
                        o_gate    <= 1'b0;
                        o_valid   <= 1'b1;
                        o_counts  <= i_counts;
                        o_windows <= o_windows + WIN_W'(1);
                    end
                end
                LATCH: begin
                    if (i_repeat && !i_stop) begin
                        state       <= CLEAR;
                        o_cnt_reset <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_gate <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed and randomized checks of gate_sequencer window timing, snapshots and counters.
module tb_gate_sequencer;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 32;
    localparam int DUR_W  = 32;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    stop;
    logic                    rpt;
    logic [DUR_W-1:0]        duration;
    logic [NUM_CH*CNT_W-1:0] counts_in;
    logic                    cnt_reset;
    logic                    gate;
    logic                    busy;
    logic                    valid;
    logic [NUM_CH*CNT_W-1:0] counts_out;
    logic [15:0]             windows;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_edge = 0;
    int          prev_valid_cyc = 0;
    logic [15:0] exp_windows = '0;
    logic [63:0] exp_counts = '0;

    gate_sequencer #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DUR_W  (DUR_W)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_repeat    (rpt),
        .i_duration  (duration),
        .i_counts    (counts_in),
        .o_cnt_reset (cnt_reset),
        .o_gate      (gate),
        .o_busy      (busy),
        .o_valid     (valid),
        .o_counts    (counts_out),
        .o_windows   (windows)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_window(input int unsigned raw);
        duration   = raw;
        start      = 1'b1;
        start_edge = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    // Called in the CLEAR cycle; walks one window and checks it against the expected timeline.
    task automatic run_window(input int unsigned raw, input bit rep, input bit stop_latch,
                              input int unsigned next_raw, input bit chained, input bit pulses);
        int          eff;
        int          pulse_cnt;
        logic [63:0] last;
        eff       = (raw == 0) ? 1 : int'(raw);
        pulse_cnt = 0;
        last      = '0;
        check_output("clear_cnt_reset", cnt_reset, 1);
        check_output("clear_gate", gate, 0);
        check_output("clear_busy", busy, 1);
        rpt       = rep;
        counts_in = '0;
        tick();
        for (int c = 1; c <= eff; c++) begin
            check_output("count_gate", gate, 1);
            check_output("count_valid", valid, 0);
            check_output("count_cnt_reset", cnt_reset, 0);
            if (pulses) begin
                if (c >= 2 && c <= 5) pulse_cnt++;
                last = {32'd0, 32'(pulse_cnt)};
            end else begin
                last = {$urandom, $urandom};
            end
            counts_in = last;
            duration  = $urandom_range(0, 9);
            start     = 1'($urandom_range(0, 1));
            tick();
        end
        start       = 1'b0;
        exp_windows = exp_windows + 16'd1;
        exp_counts  = last;
        check_output("latch_valid", valid, 1);
        check_output("latch_gate", gate, 0);
        check_output("latch_cnt_reset", cnt_reset, 0);
        check_output("latch_busy", busy, 1);
        check_output("latch_counts", counts_out, exp_counts);
        check_output("latch_windows", windows, exp_windows);
        if (chained) check_output("repeat_period", cyc - prev_valid_cyc, eff + 2);
        else         check_output("start_latency", cyc - start_edge, eff + 1);
        prev_valid_cyc = cyc;
        stop      = stop_latch;
        duration  = next_raw;
        counts_in = {$urandom, $urandom};
        tick();
        stop = 1'b0;
        if (!(rep && !stop_latch)) begin
            check_output("idle_busy", busy, 0);
            check_output("idle_valid", valid, 0);
            check_output("idle_gate", gate, 0);
            check_output("idle_counts", counts_out, exp_counts);
        end
    endtask

    initial begin
        int          n;
        int unsigned d;
        int unsigned nd;
        bit          r;
        bit          s;
        bit          saw_valid;

        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        rpt       = 1'b0;
        duration  = '0;
        counts_in = '0;
        repeat (3) tick();
        check_output("reset_cnt_reset", cnt_reset, 0);
        check_output("reset_gate", gate, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_valid", valid, 0);
        check_output("reset_counts", counts_out, 0);
        check_output("reset_windows", windows, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single shot dur=10 with 4 pulses");
        start_window(10);
        run_window(10, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        check_output("single_ch0", counts_out[31:0], 4);

        $display("[TB] zero duration");
        start_window(0);
        run_window(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] reset mid-window");
        start_window(10);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check_output("async_gate", gate, 0);
        check_output("async_cnt_reset", cnt_reset, 0);
        check_output("async_busy", busy, 0);
        repeat (3) @(posedge clk);
        tick();
        check_output("async_counts", counts_out, 0);
        check_output("async_windows", windows, 0);
        check_output("async_valid", valid, 0);
        rst         = 1'b0;
        exp_windows = '0;
        exp_counts  = '0;
        tick();
        check_output("post_reset_busy", busy, 0);

        $display("[TB] repeat dur=5 x3, stop in third latch");
        start_window(5);
        run_window(5, 1'b1, 1'b0, 5, 1'b0, 1'b0);
        run_window(5, 1'b1, 1'b0, 5, 1'b1, 1'b0);
        run_window(5, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        check_output("repeat_windows", windows, 3);
        rpt = 1'b0;

        $display("[TB] abort in fourth count cycle of dur=20");
        start_window(20);
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_output("abort_gate", gate, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_counts", counts_out, exp_counts);
        check_output("abort_windows", windows, exp_windows);
        saw_valid = 1'b0;
        repeat (25) begin
            if (valid) saw_valid = 1'b1;
            tick();
        end
        check_output("abort_no_valid", saw_valid, 0);

        $display("[TB] start and stop together");
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check_output("startstop_busy", busy, 0);
        check_output("startstop_cnt_reset", cnt_reset, 0);
        tick();
        check_output("startstop_busy_later", busy, 0);

        $display("[TB] window counter wrap");
        force dut.o_windows = 16'hFFFF;
        tick();
        release dut.o_windows;
        exp_windows = 16'hFFFF;
        check_output("wrap_preload", windows, 16'hFFFF);
        start_window(2);
        run_window(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check_output("wrap_zero", windows, 0);

        $display("[TB] randomized window chains");
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 3);
            d = $urandom_range(0, 6);
            start_window(d);
            for (int w = 0; w < n; w++) begin
                nd = $urandom_range(0, 6);
                if (w == n - 1) begin
                    r = 1'($urandom_range(0, 1));
                    s = r ? 1'b1 : 1'($urandom_range(0, 1));
                end else begin
                    r = 1'b1;
                    s = 1'b0;
                end
                run_window(d, r, s, nd, (w > 0), 1'b0);
                d = nd;
            end
            rpt = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
            check_output("rand_idle_busy", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
